reset_sequencer: RTL and testbench
==================================

RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter NSTAGE, 4, number of staged reset outputs (1..8).
REQ-002 SHALL have parameter LOCK_FILT, 16, cycles pll_lock must stay high continuously to count as locked.
REQ-003 SHALL have parameter HOLD_CYC, 64, cycles all stages stay in reset after the lock is accepted.
REQ-004 SHALL have parameter GAP_CYC, 8, cycles between successive stage releases.
REQ-005 SHALL have parameter TIMEOUT_CYC, 65535, lock-wait watchdog limit; used only with RSTSEQ_WDOG_EN.
REQ-006 SHALL have parameter PD_CYC, 32, length of the watchdog PLL power-down pulse.
REQ-007 Ports SHALL be:
  clk  input  1  system clock (33 MHz PCI); the only clock.
  reset  input  1  asynchronous active-low reset.
  user_reset  input  1  asynchronous active-low user reset request.
  pll_lock  input  1  PLL lock, asynchronous to clk.
  sw_req  input  1  one-cycle software reset request.
  clr_status  input  1  one-cycle clear of the sticky flags.
  rst_n_stage  output  NSTAGE  per-stage active-low resets; bit 0 is released first.
  pll_pwr_n  output  1  PLL POWERDOWN control; 0 powers the PLL down.
  seq_done  output  1  high only in RUN.
  lock_lost  output  1  sticky: lock dropped during RELEASE or RUN.
  lock_timeout  output  1  sticky: watchdog fired.
  loss_cnt  output  8  saturating count of lock-loss events.

Function
REQ-008 user_reset and pll_lock SHALL each pass through a 2-flop synchronizer; all decisions use the synchronized values (2-cycle input latency).
REQ-009 FSM states SHALL be ASSERT, WAIT_LOCK, HOLD, RELEASE, RUN.
REQ-010 ASSERT SHALL drive every rst_n_stage bit low and go to WAIT_LOCK the next cycle while synced user_reset=1; otherwise it stays in ASSERT.
REQ-011 WAIT_LOCK SHALL count consecutive cycles of synced pll_lock=1; any 0 clears the count; at count LOCK_FILT-1 it goes to HOLD.
REQ-012 HOLD SHALL last exactly HOLD_CYC cycles, then go to RELEASE with rst_n_stage[0]=1 in the first RELEASE cycle.
REQ-013 In RELEASE, stage k SHALL be released GAP_CYC cycles after stage k-1; released stages stay high; one cycle after the last stage is released the FSM enters RUN.
REQ-014 Stage releases SHALL be monotonic: a lower-index stage is never in reset while a higher-index stage is released.
REQ-015 Synced pll_lock=0 in HOLD, RELEASE or RUN SHALL go to ASSERT on the next cycle; from RELEASE or RUN it also sets lock_lost and increments loss_cnt, which saturates at 255.
REQ-016 sw_req in RUN SHALL go to ASSERT; sw_req in any other state SHALL be ignored and not queued.
REQ-017 Priority on simultaneous events SHALL be: synced user_reset=0, then lock loss, then sw_req.
REQ-018 A synced user_reset=0 in any state SHALL go to ASSERT on the next cycle.
REQ-019 clr_status SHALL clear lock_lost, lock_timeout and loss_cnt on the next cycle; a set event in the same cycle wins.
REQ-020 All outputs SHALL be registered.

Reset
REQ-021 While reset=0: state=ASSERT, rst_n_stage all 0, pll_pwr_n=1, seq_done=0, lock_lost=0, lock_timeout=0, loss_cnt=0, all counters and synchronizers 0.
REQ-022 Deassertion of reset SHALL start the sequence from ASSERT; there is no other path to RUN.

Configuration
REQ-023 With RSTSEQ_WDOG_EN defined: after TIMEOUT_CYC cycles in WAIT_LOCK without acceptance, the block SHALL set lock_timeout, drive pll_pwr_n=0 for PD_CYC cycles, then set pll_pwr_n=1 and restart the WAIT_LOCK count.
REQ-024 Without RSTSEQ_WDOG_EN, the block SHALL tie pll_pwr_n=1 and lock_timeout=0, and SHALL contain no watchdog counter.

Verification (NSTAGE=4, LOCK_FILT=4, HOLD_CYC=8, GAP_CYC=2, TIMEOUT_CYC=50, PD_CYC=5)
REQ-025 Release reset, user_reset=1, pll_lock=1 -> stage0 rises at a fixed cycle; stages 1/2/3 rise +2/+4/+6 cycles later; seq_done=1 one cycle after stage3.
REQ-026 pll_lock glitch low for 1 cycle during WAIT_LOCK -> lock filter restarts; HOLD is entered 4 cycles after the last synced 1-run begins.
REQ-027 pll_lock drops in RUN -> all stages low 3 cycles later (2 sync + 1); lock_lost=1; loss_cnt=1; the full sequence reruns when lock returns.
REQ-028 user_reset low and sw_req in the same RUN cycle -> ASSERT; held while user_reset=0; loss_cnt unchanged.
REQ-029 sw_req during HOLD -> ignored; the sequence completes with normal timing.
REQ-030 RSTSEQ_WDOG_EN defined, pll_lock=0 -> lock_timeout=1 after 50 WAIT_LOCK cycles; pll_pwr_n=0 for 5 cycles; then the count restarts. Then clr_status -> flags cleared.

Source files
------------

// File: rtl/reset_sequencer.sv
// Staged reset sequencer: filters PLL lock, holds all stages in reset, then releases them in order.
// Optional lock-wait watchdog with PLL power-down pulse enabled by defining RSTSEQ_WDOG_EN.
module reset_sequencer #(
    parameter int NSTAGE      = 4,
    parameter int LOCK_FILT   = 16,
    parameter int HOLD_CYC    = 64,
    parameter int GAP_CYC     = 8,
    parameter int TIMEOUT_CYC = 65535,
    parameter int PD_CYC      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              user_reset,
    input  logic              pll_lock,
    input  logic              sw_req,
    input  logic              clr_status,
    output logic [NSTAGE-1:0] rst_n_stage,
    output logic              pll_pwr_n,
    output logic              seq_done,
    output logic              lock_lost,
    output logic              lock_timeout,
    output logic [7:0]        loss_cnt
);

    if (NSTAGE < 1 || NSTAGE > 8 || LOCK_FILT < 1 || HOLD_CYC < 1 || GAP_CYC < 1 ||
        TIMEOUT_CYC < 1 || PD_CYC < 1) begin : g_param_err
        $error("reset_sequencer: illegal parameter value");
    end

    localparam int MAXC = (LOCK_FILT > HOLD_CYC) ? ((LOCK_FILT > GAP_CYC) ? LOCK_FILT : GAP_CYC)
                                                 : ((HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC);
    localparam int CW = $clog2(MAXC + 1);
    localparam logic [CW-1:0] LF_M1 = CW'(LOCK_FILT - 1);
    localparam logic [CW-1:0] HC_M1 = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] GC_M1 = CW'(GAP_CYC - 1);

    typedef enum logic [2:0] {ASSERT, WAIT_LOCK, HOLD, RELEASE, RUN} state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [NSTAGE-1:0] stage_nxt;
    logic [NSTAGE:0]   stage_shift;
    logic              seq_done_nxt;
    logic              lost_evt;
    logic              ur_s1, ur_s2, lk_s1, lk_s2;
    logic              wd_fire, pd_active;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ur_s1 <= 1'b0;
            ur_s2 <= 1'b0;
            lk_s1 <= 1'b0;
            lk_s2 <= 1'b0;
        end else begin
            ur_s1 <= user_reset;
            ur_s2 <= ur_s1;
            lk_s1 <= pll_lock;
            lk_s2 <= lk_s1;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        stage_nxt    = rst_n_stage;
        seq_done_nxt = 1'b0;
        lost_evt     = 1'b0;
        stage_shift  = {rst_n_stage, 1'b1};
        case (state)
            ASSERT: begin
                stage_nxt = '0;
                cnt_nxt   = '0;
                if (ur_s2) state_nxt = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                stage_nxt = '0;
                if (!lk_s2 || wd_fire || pd_active) begin
                    cnt_nxt = '0;
                end else if (cnt == LF_M1) begin
                    state_nxt = HOLD;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            HOLD: begin
                if (cnt == HC_M1) begin
                    state_nxt    = RELEASE;
                    cnt_nxt      = '0;
                    stage_nxt    = '0;
                    stage_nxt[0] = 1'b1;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            RELEASE: begin
                if (rst_n_stage[NSTAGE-1]) begin
                    state_nxt    = RUN;
                    seq_done_nxt = 1'b1;
                end else if (cnt == GC_M1) begin
                    // shifting in ones keeps the release order monotonic
                    stage_nxt = stage_shift[NSTAGE-1:0];
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            RUN: begin
                seq_done_nxt = 1'b1;
                if (sw_req) begin
                    state_nxt    = ASSERT;
                    stage_nxt    = '0;
                    seq_done_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt = ASSERT;
                stage_nxt = '0;
                cnt_nxt   = '0;
            end
        endcase
        // later overrides take priority: user reset beats lock loss beats sw_req
        if (!lk_s2 && (state == HOLD || state == RELEASE || state == RUN)) begin
            state_nxt    = ASSERT;
            stage_nxt    = '0;
            seq_done_nxt = 1'b0;
            cnt_nxt      = '0;
            lost_evt     = (state == RELEASE || state == RUN);
        end
        if (!ur_s2) begin
            state_nxt    = ASSERT;
            stage_nxt    = '0;
            seq_done_nxt = 1'b0;
            cnt_nxt      = '0;
            lost_evt     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ASSERT;
            cnt         <= '0;
            rst_n_stage <= '0;
            seq_done    <= 1'b0;
            lock_lost   <= 1'b0;
            loss_cnt    <= '0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            rst_n_stage <= stage_nxt;
            seq_done    <= seq_done_nxt;
            if (clr_status) begin
                lock_lost <= 1'b0;
                loss_cnt  <= '0;
            end
            if (lost_evt) begin
                lock_lost <= 1'b1;
                if (clr_status)            loss_cnt <= 8'd1;
                else if (loss_cnt != 8'hFF) loss_cnt <= loss_cnt + 8'd1;
            end
        end
    end

`ifdef RSTSEQ_WDOG_EN
    localparam int WW = $clog2(TIMEOUT_CYC + 1);
    localparam int PW = $clog2(PD_CYC + 1);
    localparam logic [WW-1:0] WD_M1 = WW'(TIMEOUT_CYC - 1);
    localparam logic [PW-1:0] PD_M1 = PW'(PD_CYC - 1);

    logic [WW-1:0] wd_cnt;
    logic [PW-1:0] pd_cnt;

    assign pd_active = !pll_pwr_n;
    assign wd_fire   = (state == WAIT_LOCK) && !pd_active && (wd_cnt == WD_M1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_cnt       <= '0;
            pd_cnt       <= '0;
            pll_pwr_n    <= 1'b1;
            lock_timeout <= 1'b0;
        end else begin
            // the wait count is frozen at zero while the PLL is powered down
            if (state != WAIT_LOCK || pd_active || wd_fire) wd_cnt <= '0;
            else                                             wd_cnt <= wd_cnt + WW'(1);
            if (wd_fire) begin
                pll_pwr_n <= 1'b0;
                pd_cnt    <= '0;
            end else if (pd_active) begin
                if (pd_cnt == PD_M1) pll_pwr_n <= 1'b1;
                pd_cnt <= pd_cnt + PW'(1);
            end
            if (clr_status) lock_timeout <= 1'b0;
            if (wd_fire)    lock_timeout <= 1'b1;
        end
    end
`else
    assign wd_fire      = 1'b0;
    assign pd_active    = 1'b0;
    assign pll_pwr_n    = 1'b1;
    assign lock_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer (NSTAGE=4, LOCK_FILT=4, HOLD_CYC=8, GAP_CYC=2, TIMEOUT_CYC=50, PD_CYC=5).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       user_reset;
    logic       pll_lock;
    logic       sw_req;
    logic       clr_status;
    logic [3:0] rst_n_stage;
    logic       pll_pwr_n;
    logic       seq_done;
    logic       lock_lost;
    logic       lock_timeout;
    logic [7:0] loss_cnt;

    int checks = 0;
    int errors = 0;

    reset_sequencer #(
        .NSTAGE(4), .LOCK_FILT(4), .HOLD_CYC(8), .GAP_CYC(2), .TIMEOUT_CYC(50), .PD_CYC(5)
    ) dut (
        .clk(clk), .reset(reset), .user_reset(user_reset), .pll_lock(pll_lock),
        .sw_req(sw_req), .clr_status(clr_status), .rst_n_stage(rst_n_stage),
        .pll_pwr_n(pll_pwr_n), .seq_done(seq_done), .lock_lost(lock_lost),
        .lock_timeout(lock_timeout), .loss_cnt(loss_cnt)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b0; user_reset = 1'b0; pll_lock = 1'b0; sw_req = 1'b0; clr_status = 1'b0;
        step(3);
        chk("rst_stages", rst_n_stage, 4'b0000);
        chk("rst_done", seq_done, 1'b0);
        chk("rst_pwr", pll_pwr_n, 1'b1);
        chk("rst_lost", lock_lost, 1'b0);
        chk("rst_tmo", lock_timeout, 1'b0);
        chk("rst_cnt", loss_cnt, 8'd0);

        // bring-up: stage0 after 15 edges, then +2/+4/+6, seq_done one later
        reset = 1'b1; user_reset = 1'b1; pll_lock = 1'b1;
        step(14); chk("up_pre", rst_n_stage, 4'b0000);
        step(1);  chk("up_s0", rst_n_stage, 4'b0001);
        step(1);  chk("up_s0b", rst_n_stage, 4'b0001);
        step(1);  chk("up_s1", rst_n_stage, 4'b0011);
        step(2);  chk("up_s2", rst_n_stage, 4'b0111);
        step(2);  chk("up_s3", rst_n_stage, 4'b1111);
                  chk("up_done_pre", seq_done, 1'b0);
        step(1);  chk("up_done", seq_done, 1'b1);

        // lock loss in RUN
        pll_lock = 1'b0;
        step(2);  chk("ll_pre", rst_n_stage, 4'b1111);
        step(1);  chk("ll_stages", rst_n_stage, 4'b0000);
                  chk("ll_lost", lock_lost, 1'b1);
                  chk("ll_cnt", loss_cnt, 8'd1);
                  chk("ll_done", seq_done, 1'b0);
        pll_lock = 1'b1;
        step(13); chk("ll_re_pre", rst_n_stage, 4'b0000);
        step(1);  chk("ll_re_s0", rst_n_stage, 4'b0001);
        step(7);  chk("ll_re_all", rst_n_stage, 4'b1111);
                  chk("ll_re_done", seq_done, 1'b1);

        // sw_req in RUN restarts the sequence without counting a loss
        sw_req = 1'b1;
        step(1); sw_req = 1'b0;
        chk("sw_stages", rst_n_stage, 4'b0000);
        chk("sw_done", seq_done, 1'b0);
        chk("sw_cnt", loss_cnt, 8'd1);
        step(12); chk("sw_re_pre", rst_n_stage, 4'b0000);
        step(1);  chk("sw_re_s0", rst_n_stage, 4'b0001);
        step(7);  chk("sw_re_done", seq_done, 1'b1);

        clr_status = 1'b1;
        step(1); clr_status = 1'b0;
        chk("clr_lost", lock_lost, 1'b0);
        chk("clr_cnt", loss_cnt, 8'd0);
        chk("clr_done", seq_done, 1'b1);

        // user_reset low with sw_req in RUN; held in ASSERT
        user_reset = 1'b0; sw_req = 1'b1;
        step(1); sw_req = 1'b0;
        chk("ur_stages", rst_n_stage, 4'b0000);
        step(10);
        chk("ur_hold", rst_n_stage, 4'b0000);
        chk("ur_done", seq_done, 1'b0);
        chk("ur_cnt", loss_cnt, 8'd0);

        // release user_reset; sw_req during HOLD is ignored
        user_reset = 1'b1;
        step(9); sw_req = 1'b1;
        step(1); sw_req = 1'b0;
        chk("hsw_mid", rst_n_stage, 4'b0000);
        step(4);  chk("hsw_pre", rst_n_stage, 4'b0000);
        step(1);  chk("hsw_s0", rst_n_stage, 4'b0001);
        step(6);  chk("hsw_all", rst_n_stage, 4'b1111);
        step(1);  chk("hsw_done", seq_done, 1'b1);

        // user_reset and lock loss together: user reset wins, no loss counted
        user_reset = 1'b0; pll_lock = 1'b0;
        step(3);
        chk("pri_stages", rst_n_stage, 4'b0000);
        chk("pri_lost", lock_lost, 1'b0);
        chk("pri_cnt", loss_cnt, 8'd0);

        // one-cycle lock glitch in WAIT_LOCK restarts the filter
        user_reset = 1'b1;
        step(3); pll_lock = 1'b1;
        step(2); pll_lock = 1'b0;
        step(1); pll_lock = 1'b1;
        step(13); chk("gl_pre", rst_n_stage, 4'b0000);
        step(1);  chk("gl_s0", rst_n_stage, 4'b0001);
        step(7);  chk("gl_done", seq_done, 1'b1);

        // lock drop, then stay unlocked in WAIT_LOCK
        pll_lock = 1'b0;
        step(3);
        chk("wd_lost", lock_lost, 1'b1);
        chk("wd_cnt", loss_cnt, 8'd1);
`ifdef RSTSEQ_WDOG_EN
        step(50); chk("wd_pre_tmo", lock_timeout, 1'b0);
                  chk("wd_pre_pwr", pll_pwr_n, 1'b1);
        step(1);  chk("wd_tmo", lock_timeout, 1'b1);
                  chk("wd_pd_start", pll_pwr_n, 1'b0);
        step(4);  chk("wd_pd_end", pll_pwr_n, 1'b0);
        step(1);  chk("wd_pd_off", pll_pwr_n, 1'b1);
        step(49); chk("wd_re_pre", pll_pwr_n, 1'b1);
        step(1);  chk("wd_re_fire", pll_pwr_n, 1'b0);
`else
        step(60);
        chk("nowd_pwr", pll_pwr_n, 1'b1);
        chk("nowd_tmo", lock_timeout, 1'b0);
        chk("nowd_stages", rst_n_stage, 4'b0000);
`endif
        clr_status = 1'b1;
        step(1); clr_status = 1'b0;
        chk("wclr_tmo", lock_timeout, 1'b0);
        chk("wclr_lost", lock_lost, 1'b0);
        chk("wclr_cnt", loss_cnt, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
